instruction_queue_issue: RTL and testbench

- In-order instruction queue and issue stage that sits directly upstream of the adder reservation stations and the load/store reservation stations.
- Buffers 16-bit instructions from fetch.
- Classifies each instruction by opcode:
  - Add class: opcode[3:0] = 0000, 0001 or 0100.
  - Load/store class: all other opcodes.
- Issues the head instruction as a one-cycle enable pulse to the target unit only when that unit reports a free station.

---
 rtl/instruction_queue_issue.sv | 123 ++++++++++++
 tb/tb_instruction_queue_issue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue_issue.sv
// In-order instruction queue feeding the adder and load/store reservation stations.
// Issues the head as a one-cycle enable pulse, at most one instruction every two cycles.
module instruction_queue_issue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned WIDTH  = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [WIDTH-1:0]  instIn,
    input  logic              instInValid,
    output logic              instInReady,
    input  logic              flush,
    output logic [WIDTH-1:0]  instruction,
    output logic              Adderin,
    output logic              LSin,
    input  logic              disponivel,
    input  logic              disponivelLS,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic [7:0]        stallCycles
);

    typedef enum logic [1:0] {StIdle, StBlocked, StIssue, StGap} state_e;

    localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CountOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  inst_q;
    logic              adder_q, ls_q;
    logic [7:0]        stall_q;

    logic [WIDTH-1:0]  head;
    logic              head_is_add;
    logic              target_ready;
    logic              push, issue;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CountFull);
    assign instInReady = !full;
    assign count       = count_q;
    assign instruction = inst_q;
    assign Adderin     = adder_q;
    assign LSin        = ls_q;
    assign stallCycles = stall_q;

    assign head         = mem[rd_ptr_q];
    assign head_is_add  = head[3:0] inside {4'b0000, 4'b0001, 4'b0100};
    assign target_ready = head_is_add ? disponivel : disponivelLS;
    assign push         = instInValid && !full;

    // ISSUE never evaluates: the RS availability flags are stale until its Busy update lands.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle, StBlocked, StGap: begin
                if (empty) begin
                    state_d = StIdle;
                end else if (target_ready) begin
                    issue   = 1'b1;
                    state_d = StIssue;
                end else begin
                    state_d = StBlocked;
                end
            end
            StIssue: state_d = StGap;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= instIn;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            inst_q   <= '0;
            adder_q  <= 1'b0;
            ls_q     <= 1'b0;
            stall_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            adder_q  <= 1'b0;
            ls_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            adder_q <= issue && head_is_add;
            ls_q    <= issue && !head_is_add;
            if (issue) begin
                inst_q   <= head;
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (push && !issue) begin
                count_q <= count_q + CountOne;
            end else if (!push && issue) begin
                count_q <= count_q - CountOne;
            end
            if (state_q == StBlocked && stall_q != 8'hFF) begin
                stall_q <= stall_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_queue_issue.sv
// Directed bench for instruction_queue_issue: issue timing, stalls, full queue, ordering,
// flush and asynchronous reset, all against hand-computed expectations.
module tb_instruction_queue_issue;

    logic        Clock;
    logic        Resetn;
    logic [15:0] instIn;
    logic        instInValid;
    logic        instInReady;
    logic        flush;
    logic [15:0] instruction;
    logic        Adderin;
    logic        LSin;
    logic        disponivel;
    logic        disponivelLS;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic [7:0]  stallCycles;

    int checks = 0;
    int errors = 0;

    logic [15:0] vec [9];

    instruction_queue_issue #(
        .DEPTH  (8),
        .ADDR_W (3),
        .WIDTH  (16)
    ) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .instIn       (instIn),
        .instInValid  (instInValid),
        .instInReady  (instInReady),
        .flush        (flush),
        .instruction  (instruction),
        .Adderin      (Adderin),
        .LSin         (LSin),
        .disponivel   (disponivel),
        .disponivelLS (disponivelLS),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .stallCycles  (stallCycles)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulses(input string tag, input logic add_exp, input logic ls_exp);
        check_eq({tag, "_add"}, {31'd0, Adderin}, {31'd0, add_exp});
        check_eq({tag, "_ls"}, {31'd0, LSin}, {31'd0, ls_exp});
    endtask

    initial begin
        Resetn       = 1'b0;
        instIn       = '0;
        instInValid  = 1'b0;
        flush        = 1'b0;
        disponivel   = 1'b1;
        disponivelLS = 1'b1;
        for (int i = 0; i < 9; i++) begin
            vec[i] = (16'h0100 * 16'(i + 1)) | (i[0] ? 16'h0008 : 16'h0004);
        end

        // Reset state
        step();
        step();
        check_eq("rst_count", {28'd0, count}, 32'd0);
        check_eq("rst_empty", {31'd0, empty}, 32'd1);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        check_eq("rst_ready", {31'd0, instInReady}, 32'd1);
        check_eq("rst_instr", {16'd0, instruction}, 32'd0);
        check_eq("rst_stall", {24'd0, stallCycles}, 32'd0);
        pulses("rst", 1'b0, 1'b0);
        Resetn = 1'b1;
        step();

        // Add-class instruction issues two edges after its push
        instIn      = 16'h0C81;
        instInValid = 1'b1;
        step();
        instInValid = 1'b0;
        check_eq("t1_count_push", {28'd0, count}, 32'd1);
        pulses("t1_nofall", 1'b0, 1'b0);
        step();
        pulses("t1_issue", 1'b1, 1'b0);
        check_eq("t1_instr", {16'd0, instruction}, 32'h0C81);
        check_eq("t1_count_pop", {28'd0, count}, 32'd0);
        step();
        pulses("t1_drop", 1'b0, 1'b0);
        check_eq("t1_instr_hold", {16'd0, instruction}, 32'h0C81);
        step();

        // Load/store head blocked for five edges
        disponivelLS = 1'b0;
        instIn       = 16'h0002;
        instInValid  = 1'b1;
        step();
        instInValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses("t2_blocked", 1'b0, 1'b0);
        end
        disponivelLS = 1'b1;
        step();
        pulses("t2_issue", 1'b0, 1'b1);
        check_eq("t2_instr", {16'd0, instruction}, 32'h0002);
        check_eq("t2_stall", {24'd0, stallCycles}, 32'd5);
        step();
        pulses("t2_drop", 1'b0, 1'b0);
        step();

        // Fill to full; the ninth push is refused
        disponivel   = 1'b0;
        disponivelLS = 1'b0;
        for (int i = 0; i < 9; i++) begin
            instIn      = vec[i];
            instInValid = 1'b1;
            if (i == 8) begin
                check_eq("t3_ready_full", {31'd0, instInReady}, 32'd0);
                check_eq("t3_full", {31'd0, full}, 32'd1);
            end
            step();
        end
        instInValid = 1'b0;
        check_eq("t3_count8", {28'd0, count}, 32'd8);
        pulses("t3_held", 1'b0, 1'b0);
        disponivel   = 1'b1;
        disponivelLS = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            pulses("t3_issue", !vec[j][3], vec[j][3]);
            check_eq("t3_order", {16'd0, instruction}, {16'd0, vec[j]});
            step();
            pulses("t3_gap", 1'b0, 1'b0);
        end
        check_eq("t3_empty", {31'd0, empty}, 32'd1);
        check_eq("t3_stall", {24'd0, stallCycles}, 32'd13);

        // Blocked add head holds back a ready load/store behind it
        disponivel  = 1'b0;
        instIn      = 16'h0C80;
        instInValid = 1'b1;
        step();
        instIn = 16'h0003;
        step();
        instInValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses("t4_inorder", 1'b0, 1'b0);
        end
        check_eq("t4_count", {28'd0, count}, 32'd2);
        disponivel = 1'b1;
        step();
        pulses("t4_add", 1'b1, 1'b0);
        check_eq("t4_add_instr", {16'd0, instruction}, 32'h0C80);
        step();
        pulses("t4_gap", 1'b0, 1'b0);
        step();
        pulses("t4_ls", 1'b0, 1'b1);
        check_eq("t4_ls_instr", {16'd0, instruction}, 32'h0003);
        step();
        step();

        // Flush during ISSUE with four entries still queued
        disponivel  = 1'b0;
        instInValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instIn = 16'h0011 + 16'(i * 16);
            step();
        end
        instInValid = 1'b0;
        disponivel  = 1'b1;
        step();
        pulses("t5_issue", 1'b1, 1'b0);
        check_eq("t5_count4", {28'd0, count}, 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t5_count0", {28'd0, count}, 32'd0);
        check_eq("t5_empty", {31'd0, empty}, 32'd1);
        check_eq("t5_stall_kept", {24'd0, stallCycles}, 32'd21);
        pulses("t5_flush", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            pulses("t5_quiet", 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of an Adderin pulse
        instIn      = 16'h0C81;
        instInValid = 1'b1;
        step();
        instInValid = 1'b0;
        step();
        pulses("t6_pulse", 1'b1, 1'b0);
        #2;
        Resetn = 1'b0;
        #1;
        pulses("t6_async", 1'b0, 1'b0);
        check_eq("t6_instr", {16'd0, instruction}, 32'd0);
        check_eq("t6_count", {28'd0, count}, 32'd0);
        check_eq("t6_empty", {31'd0, empty}, 32'd1);
        check_eq("t6_stall", {24'd0, stallCycles}, 32'd0);
        step();
        Resetn = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
